// File: rtl/usrt_tx.sv
// Synchronous serial transmitter: 11-bit frames (start, 8 data LSB first, parity, stop) paced by i_Bclk.
// Define USRT_TX_HOLD_EN to add an 8-bit holding register for back-to-back frames.
module usrt_tx (
  input  logic       i_Pclk,
  input  logic       i_Reset,
  input  logic       i_Bclk,
  input  logic       i_Push,
  input  logic [7:0] i_Data,
  input  logic [1:0] i_Parity,
  output logic       o_Tx_Serial,
  output logic       o_Busy,
  output logic       o_Full,
  output logic       o_Done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_reg, state_next;
  logic       bclk_reg;
  logic       tick;
  logic [7:0] data_reg;
  logic       par_reg;
  logic [2:0] cnt_reg, cnt_next;
  logic       pend_reg;
  logic       tx_reg, tx_next;
  logic       done_reg, done_next;
  logic       accept;
  logic       load;
  logic       cap_par;

  assign tick = i_Bclk & ~bclk_reg;

  // Parity is frozen at capture so later i_Parity changes cannot corrupt a queued or active frame.
  always_comb begin
    case (i_Parity)
      2'd1:    cap_par = ^i_Data;
      2'd2:    cap_par = ~^i_Data;
      default: cap_par = 1'b1;
    endcase
  end

  assign o_Busy = (state_reg != IDLE);

`ifdef USRT_TX_HOLD_EN
  logic [7:0] hold_data_reg;
  logic       hold_par_reg;
  assign o_Full = pend_reg;
`else
  assign o_Full = o_Busy | pend_reg;
`endif

  assign accept = i_Push & ~o_Full;
  assign load   = tick & pend_reg & ((state_reg == IDLE) | (state_reg == STOP));

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_reg <= IDLE;
      bclk_reg  <= 1'b0;
      cnt_reg   <= 3'd0;
      pend_reg  <= 1'b0;
      data_reg  <= 8'd0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
`ifdef USRT_TX_HOLD_EN
      hold_data_reg <= 8'd0;
      hold_par_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      bclk_reg  <= i_Bclk;
      cnt_reg   <= cnt_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
`ifdef USRT_TX_HOLD_EN
      if (accept) begin
        hold_data_reg <= i_Data;
        hold_par_reg  <= cap_par;
      end
      if (load) begin
        data_reg <= hold_data_reg;
        par_reg  <= hold_par_reg;
      end
`else
      if (accept) begin
        data_reg <= i_Data;
        par_reg  <= cap_par;
      end
`endif
      // accept needs an empty slot and load needs a full one, so they never coincide
      if (accept)
        pend_reg <= 1'b1;
      else if (load)
        pend_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (tick && pend_reg) begin
          state_next = START;
          cnt_next   = 3'd0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          cnt_next   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_reg == 3'd7)
            state_next = PARITY;
          cnt_next = cnt_reg + 3'd1;
        end
      end
      PARITY: begin
        if (tick)
          state_next = STOP;
      end
      STOP: begin
        if (tick)
          state_next = pend_reg ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level follows the state being entered, so it changes on the clock after a tick.
  always_comb begin
    tx_next   = 1'b1;
    done_next = tick && (state_reg == STOP);
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[cnt_next];
      PARITY:  tx_next = par_reg;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign o_Tx_Serial = tx_reg;
  assign o_Done      = done_reg;

endmodule

// File: tb/tb_usrt_tx.sv
// Self-checking bench for usrt_tx: a line monitor decodes frames and compares them with a byte/parity model.
module tb_usrt_tx;

  localparam int BAUD = 8;

  logic       i_Pclk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Bclk = 1'b0;
  logic       i_Push = 1'b0;
  logic [7:0] i_Data = 8'd0;
  logic [1:0] i_Parity = 2'd0;
  logic       o_Tx_Serial;
  logic       o_Busy;
  logic       o_Full;
  logic       o_Done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bcnt = 0;

  logic [10:0] rx_q[$];
  int          start_q[$];
  int          done_pulses = 0;
  int          done_cycles = 0;
  logic        prev_done = 1'b0;
  logic        prev_tx = 1'b1;
  bit          mon_active = 0;
  int          mon_cnt = 0;
  logic [10:0] mon_bits = '0;

  usrt_tx dut (
    .i_Pclk(i_Pclk),
    .i_Reset(i_Reset),
    .i_Bclk(i_Bclk),
    .i_Push(i_Push),
    .i_Data(i_Data),
    .i_Parity(i_Parity),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Busy(o_Busy),
    .o_Full(o_Full),
    .o_Done(o_Done)
  );

  always #5 i_Pclk = ~i_Pclk;

  always @(posedge i_Pclk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge i_Pclk);
      bcnt = (bcnt + 1) % BAUD;
      i_Bclk = (bcnt < BAUD / 2);
    end
  end

  // Receiver: finds the start edge and samples every bit at its centre.
  always @(negedge i_Pclk) begin
    int idx;
    if (o_Done) done_cycles++;
    if (o_Done && !prev_done) done_pulses++;
    prev_done = o_Done;
    if (i_Reset) begin
      mon_active = 0;
      prev_tx = 1'b1;
    end else begin
      if (mon_active) begin
        mon_cnt++;
        if (mon_cnt % BAUD == BAUD / 2) begin
          idx = mon_cnt / BAUD;
          mon_bits[idx] = o_Tx_Serial;
          if (idx == 10) begin
            rx_q.push_back(mon_bits);
            mon_active = 0;
          end
        end
      end else if (prev_tx && !o_Tx_Serial) begin
        mon_active = 1;
        mon_cnt = 0;
        mon_bits = '0;
        start_q.push_back(cyc);
      end
      prev_tx = o_Tx_Serial;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic [1:0] p);
    int ones = 0;
    logic pb;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (p == 2'd1) pb = (ones % 2 == 1);
    else if (p == 2'd2) pb = (ones % 2 == 0);
    else pb = 1'b1;
    return {1'b1, pb, d, 1'b0};
  endfunction

  task automatic push(input logic [7:0] d);
    @(negedge i_Pclk);
    i_Push = 1'b1;
    i_Data = d;
    @(negedge i_Pclk);
    i_Push = 1'b0;
  endtask

  task automatic sync_after_tick();
    do @(posedge i_Pclk); while (bcnt != 1);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < 40 * BAUD * n) begin
      @(negedge i_Pclk);
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int k = 0;
    @(negedge i_Pclk);
    while (o_Busy && k < 30 * BAUD) begin
      @(negedge i_Pclk);
      k++;
    end
    ok = !o_Busy;
    repeat (3) @(negedge i_Pclk);
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (5) @(negedge i_Pclk);
    checks++; if (o_Tx_Serial !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", o_Tx_Serial); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", o_Busy); end
    checks++; if (o_Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", o_Full); end
    checks++; if (o_Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", o_Done); end
    i_Reset = 1'b0;
    repeat (2) @(negedge i_Pclk);
    $display("reset: tx=%b busy=%b full=%b done=%b", o_Tx_Serial, o_Busy, o_Full, o_Done);
  endtask

  task automatic test_vectors();
    logic [7:0]  vd[3] = '{8'h35, 8'h5D, 8'h00};
    logic [1:0]  vp[3] = '{2'd1, 2'd2, 2'd0};
    logic [10:0] vf[3] = '{11'b10001101010, 11'b10010111010, 11'b11000000000};
    for (int i = 0; i < 3; i++) begin
      int d0 = done_pulses;
      bit ok;
      logic [10:0] got;
      rx_q.delete();
      i_Parity = vp[i];
      sync_after_tick();
      push(vd[i]);
      checks++; if (o_Full !== 1'b1) begin errors++; $display("FAIL vec%0d_full got=%b want=1", i, o_Full); end
      wait_rx(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL vec%0d_timeout frames=%0d want=1", i, rx_q.size()); end
      got = ok ? rx_q.pop_front() : 11'bx;
      checks++; if (got !== vf[i]) begin errors++; $display("FAIL vec%0d_frame got=%b want=%b", i, got, vf[i]); end
      checks++; if (got !== model_frame(vd[i], vp[i])) begin errors++; $display("FAIL vec%0d_model got=%b want=%b", i, got, model_frame(vd[i], vp[i])); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL vec%0d_busy got=%b want=0", i, o_Busy); end
      checks++; if (done_pulses !== d0 + 1) begin errors++; $display("FAIL vec%0d_done got=%0d want=%0d", i, done_pulses - d0, 1); end
      checks++; if (done_cycles !== done_pulses) begin errors++; $display("FAIL vec%0d_done_width got=%0d want=%0d", i, done_cycles, done_pulses); end
      $display("vector %0d: data=%h par=%0d line=%b", i, vd[i], vp[i], got);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d = 8'($urandom);
      logic [1:0] p = 2'($urandom_range(0, 3));
      logic [10:0] got;
      bit ok;
      rx_q.delete();
      i_Parity = p;
      push(d);
      i_Parity = ~p;
      wait_rx(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout frames=%0d want=1", i, rx_q.size()); end
      got = ok ? rx_q.pop_front() : 11'bx;
      checks++; if (got !== model_frame(d, p)) begin errors++; $display("FAIL rand%0d_frame got=%b want=%b", i, got, model_frame(d, p)); end
      wait_idle(ok);
      $display("random %0d: data=%h par=%0d line=%b", i, d, p, got);
    end
  endtask

  task automatic test_drop();
    int d0 = done_pulses;
    bit ok;
    logic [10:0] got;
    rx_q.delete();
    start_q.delete();
    i_Parity = 2'd1;
    sync_after_tick();
    push(8'hA5);
    checks++; if (o_Full !== 1'b1) begin errors++; $display("FAIL drop_full got=%b want=1", o_Full); end
    push(8'h3C);
    wait_rx(1, ok);
    got = ok ? rx_q.pop_front() : 11'bx;
    checks++; if (got !== model_frame(8'hA5, 2'd1)) begin errors++; $display("FAIL drop_frame got=%b want=%b", got, model_frame(8'hA5, 2'd1)); end
    wait_idle(ok);
    repeat (12 * BAUD) @(negedge i_Pclk);
    checks++; if (start_q.size() != 1) begin errors++; $display("FAIL drop_frames got=%0d want=1", start_q.size()); end
    checks++; if (done_pulses !== d0 + 1) begin errors++; $display("FAIL drop_done got=%0d want=1", done_pulses - d0); end
    $display("drop: frames=%0d line=%b", start_q.size(), got);
  endtask

  task automatic test_reset_mid();
    int d0 = done_pulses;
    int k = 0;
    rx_q.delete();
    start_q.delete();
    i_Parity = 2'd1;
    push(8'h5A);
    while (start_q.size() == 0 && k < 4 * BAUD) begin @(negedge i_Pclk); k++; end
    checks++; if (start_q.size() == 0) begin errors++; $display("FAIL rstmid_start got=0 want=1"); end
    repeat (4 * BAUD + BAUD / 2 - 1) @(negedge i_Pclk);
    i_Reset = 1'b1;
    i_Push = 1'b1;
    i_Data = 8'hFF;
    @(posedge i_Pclk);
    #1;
    checks++; if (o_Tx_Serial !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b want=1", o_Tx_Serial); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", o_Busy); end
    checks++; if (o_Done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", o_Done); end
    checks++; if (o_Full !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b want=0", o_Full); end
    @(negedge i_Pclk);
    i_Reset = 1'b0;
    i_Push = 1'b0;
    repeat (14 * BAUD) @(negedge i_Pclk);
    checks++; if (done_pulses !== d0) begin errors++; $display("FAIL rstmid_nodone got=%0d want=0", done_pulses - d0); end
    checks++; if (rx_q.size() != 0 || start_q.size() != 1) begin errors++; $display("FAIL rstmid_frames got=%0d/%0d want=0/1", rx_q.size(), start_q.size()); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b want=0", o_Busy); end
    $display("reset mid-frame: done=%0d frames=%0d", done_pulses - d0, rx_q.size());
  endtask

  task automatic test_back_to_back();
    int d0 = done_pulses;
    int k = 0;
    bit ok;
    logic [10:0] got;
    rx_q.delete();
    start_q.delete();
    i_Parity = 2'd1;
    push(8'h35);
    while (!o_Busy && k < 4 * BAUD) begin @(negedge i_Pclk); k++; end
    repeat (2 * BAUD) @(negedge i_Pclk);
    i_Parity = 2'd2;
`ifdef USRT_TX_HOLD_EN
    checks++; if (o_Full !== 1'b0) begin errors++; $display("FAIL b2b_full_before got=%b want=0", o_Full); end
    push(8'h5D);
    checks++; if (o_Full !== 1'b1) begin errors++; $display("FAIL b2b_full_after got=%b want=1", o_Full); end
    wait_rx(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout frames=%0d want=2", rx_q.size()); end
    got = ok ? rx_q.pop_front() : 11'bx;
    checks++; if (got !== model_frame(8'h35, 2'd1)) begin errors++; $display("FAIL b2b_frame1 got=%b want=%b", got, model_frame(8'h35, 2'd1)); end
    got = ok ? rx_q.pop_front() : 11'bx;
    checks++; if (got !== model_frame(8'h5D, 2'd2)) begin errors++; $display("FAIL b2b_frame2 got=%b want=%b", got, model_frame(8'h5D, 2'd2)); end
    checks++; if (start_q.size() < 2 || start_q[1] - start_q[0] != 11 * BAUD) begin errors++; $display("FAIL b2b_gap got=%0d want=%0d", start_q.size() < 2 ? -1 : start_q[1] - start_q[0], 11 * BAUD); end
    wait_idle(ok);
    checks++; if (done_pulses !== d0 + 2) begin errors++; $display("FAIL b2b_done got=%0d want=2", done_pulses - d0); end
`else
    checks++; if (o_Full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b want=1", o_Full); end
    push(8'h5D);
    wait_rx(1, ok);
    got = ok ? rx_q.pop_front() : 11'bx;
    checks++; if (got !== model_frame(8'h35, 2'd1)) begin errors++; $display("FAIL b2b_frame1 got=%b want=%b", got, model_frame(8'h35, 2'd1)); end
    wait_idle(ok);
    repeat (12 * BAUD) @(negedge i_Pclk);
    checks++; if (start_q.size() != 1) begin errors++; $display("FAIL b2b_frames got=%0d want=1", start_q.size()); end
    checks++; if (done_pulses !== d0 + 1) begin errors++; $display("FAIL b2b_done got=%0d want=1", done_pulses - d0); end
`endif
    $display("back-to-back: frames=%0d done=%0d", start_q.size(), done_pulses - d0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usrt_tx.md
USRT_TX -- requirements
Module: usrt_tx

Interface
REQ-001 SHALL have parameter none; frame is fixed at 11 bits: start(0), 8 data bits LSB first, parity, stop(1).
REQ-002 SHALL have port i_Pclk  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_Bclk  input  1  baud clock from baudgen, sampled in the i_Pclk domain.
REQ-005 SHALL have port i_Push  input  1  one-cycle write strobe from the bus interface.
REQ-006 SHALL have port i_Data  input  8  byte to transmit, captured when i_Push is accepted.
REQ-007 SHALL have port i_Parity  input  2  parity mode from the status register: 1 = EVEN, 2 = ODD, 0 or 3 = none.
REQ-008 SHALL have port o_Tx_Serial  output  1  serial line, idle high.
REQ-009 SHALL have port o_Busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port o_Full  output  1  high when no further push can be accepted.
REQ-011 SHALL have port o_Done  output  1  one-i_Pclk pulse at the end of each stop bit.

Function
REQ-012 SHALL detect the baud tick as i_Bclk high and registered i_Bclk low (rising edge), giving one tick per Bclk period.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL accept i_Push only when o_Full is low; a push while o_Full is high SHALL be ignored with no state change.
REQ-015 SHALL compute the parity bit at capture time: EVEN gives XOR of the data bits; ODD gives its inverse; none gives 1.
REQ-016 SHALL move IDLE->START on the first baud tick after a pending byte exists; o_Tx_Serial SHALL go to 0 on the clock after that tick.
REQ-017 SHALL hold each bit for exactly one baud tick interval and change o_Tx_Serial only on the clock after a tick.
REQ-018 SHALL send data bits 0..7 in DATA with a 3-bit counter that wraps from 7 to 0 on exit to PARITY.
REQ-019 SHALL send PARITY, then STOP (line 1); the tick ending STOP SHALL assert o_Done for one cycle.
REQ-020 SHALL go from STOP to START on that same tick if another byte is pending, giving no idle gap; otherwise it SHALL go to IDLE.
REQ-021 SHALL assert o_Busy in every state except IDLE.
REQ-022 SHALL ignore i_Parity changes during a frame, because the parity bit is fixed at capture.

Reset
REQ-023 SHALL, on i_Reset, on the next clock: FSM to IDLE, o_Tx_Serial=1, o_Busy=0, o_Full=0, o_Done=0, counter=0, pending/hold data cleared.
REQ-024 SHALL abort a frame interrupted by reset mid-operation, with no o_Done; a push in the reset cycle SHALL be ignored.

Configuration
REQ-025 SHALL compile in an 8-bit holding register when macro USRT_TX_HOLD_EN is defined.
REQ-026 SHALL, with USRT_TX_HOLD_EN defined:
- o_Full = holding register occupied.
- A push during a frame fills the holding register.
- The holding register transfers to the shifter at the START transition and clears in the same cycle.
- A push in that exact cycle is still ignored, since o_Full was sampled high.
REQ-027 SHALL, without USRT_TX_HOLD_EN:
- o_Full = o_Busy OR byte pending.
- A push is accepted only in IDLE with nothing pending.
- No back-to-back frames occur.

Verification
REQ-028 SHALL verify: i_Parity=1, push 0x35 -> line sequence LSB-first 11'b10001101010, o_Done pulses once, o_Busy falls after.
REQ-029 SHALL verify: i_Parity=2, push 0x5D -> 11'b10010111010 on the line.
REQ-030 SHALL verify: i_Parity=0, push 0x00 -> 11'b11000000000 (parity slot 1).
REQ-031 SHALL verify: push 0xA5 then a second push while o_Full=1 -> second byte dropped, exactly one frame sent.
REQ-032 SHALL verify: i_Reset asserted during DATA bit 3 -> o_Tx_Serial=1, o_Busy=0 next clock, no o_Done.
REQ-033 SHALL verify: with USRT_TX_HOLD_EN, push 0x35 then 0x5D mid-frame -> two frames with stop of first directly followed by start of second, two o_Done pulses.
